// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Pointers carry one extra wrap bit so full and empty can be told apart
// without a separate occupancy counter.
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,     // active-high despite the name
    input  logic             w_en,
    input  logic             r_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] PtrOne = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic wr_acc;
    logic rd_acc;

    // Flags decode from registered pointers; requests gated by pre-edge flags.
    always_comb begin
        empty  = (wptr_q == rptr_q);
        full   = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        wr_acc = w_en && !full;
        rd_acc = r_en && !empty;
    end

    // Next-state for pointers and the read-data register.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        data_out_d = data_out_q;
        if (wr_acc) begin
            wptr_d = wptr_q + PtrOne;
        end
        if (rd_acc) begin
            rptr_d     = rptr_q + PtrOne;
            data_out_d = mem[rptr_q[AW-1:0]];
        end
    end

    // Pointer and read-data state; async reset discards all queued data.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            data_out_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage array is not reset; only accepted writes land.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr_q[AW-1:0]] <= data_in;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model compared
// every falling edge, plus directed literal expectations.
module tb_sync_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             w_en;
    logic             r_en;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_dout;

    sync_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .w_en     (w_en),
        .r_en     (r_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO as a queue; acceptance decided by occupancy before the edge.
    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mq.delete();
            m_dout = '0;
        end else begin
            bit wacc, racc;
            wacc = w_en && (mq.size() < DEPTH);
            racc = r_en && (mq.size() > 0);
            if (racc) m_dout = mq.pop_front();
            if (wacc) mq.push_back(data_in);
        end
    end

    // Compare process: outputs against model on every falling edge.
    always @(negedge clk) begin
        check("model_dout", 32'(data_out), 32'(m_dout));
        check("model_full", 32'(full), 32'(mq.size() == DEPTH));
        check("model_empty", 32'(empty), 32'(mq.size() == 0));
    end

    // One request cycle: drive, wait for the edge, release, settle.
    task automatic cyc(input logic we, input logic re, input logic [WIDTH-1:0] d);
        w_en    = we;
        r_en    = re;
        data_in = d;
        @(posedge clk);
        #1;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int occ;
        int sent;
        int iter;
        int r;
        rst_n   = 1'b1;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = '0;
        #12 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("init_empty", 32'(empty), 32'd1);
        check("init_full", 32'(full), 32'd0);
        check("init_dout", 32'(data_out), 32'd0);

        // 1. Reset mid-operation, asserted between edges.
        cyc(1'b1, 1'b0, 8'hA1);
        cyc(1'b1, 1'b0, 8'hA2);
        cyc(1'b1, 1'b0, 8'hA3);
        cyc(1'b0, 1'b1, 8'h00);
        check("pre_rst_dout", 32'(data_out), 32'hA1);
        #2 rst_n = 1'b1;
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        #9 rst_n = 1'b0;
        @(posedge clk);
        #1;

        // 2. Fill then drain.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            if (i == 7) check("fill7_full", 32'(full), 32'd0);
        end
        check("fill8_full", 32'(full), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            check("drain_dout", 32'(data_out), 32'(i));
        end
        check("drain_empty", 32'(empty), 32'd1);

        // 3. Overflow ignored.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 8'(i));
        cyc(1'b1, 1'b0, 8'hFF);
        check("ovf_full", 32'(full), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            check("ovf_drain", 32'(data_out), 32'(i));
        end

        // 4. Underflow ignored; pointers unchanged.
        cyc(1'b0, 1'b1, 8'h00);
        check("unf_dout", 32'(data_out), 32'h08);
        check("unf_empty", 32'(empty), 32'd1);
        cyc(1'b1, 1'b0, 8'h55);
        cyc(1'b0, 1'b1, 8'h00);
        check("unf_after", 32'(data_out), 32'h55);

        // 5a. Simultaneous with 3 entries.
        cyc(1'b1, 1'b0, 8'h10);
        cyc(1'b1, 1'b0, 8'h11);
        cyc(1'b1, 1'b0, 8'h12);
        begin
            logic [7:0] exp_sim [4];
            exp_sim = '{8'h10, 8'h11, 8'h12, 8'h20};
            for (int i = 0; i < 4; i++) begin
                cyc(1'b1, 1'b1, 8'(8'h20 + i));
                check("sim_dout", 32'(data_out), 32'(exp_sim[i]));
            end
        end
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            check("sim_drain", 32'(data_out), 32'(8'h20 + i));
        end
        check("sim_empty", 32'(empty), 32'd1);

        // 5b. Simultaneous when empty: only the write lands.
        cyc(1'b1, 1'b1, 8'h77);
        check("simE_dout", 32'(data_out), 32'h23);
        check("simE_empty", 32'(empty), 32'd0);
        cyc(1'b0, 1'b1, 8'h00);
        check("simE_read", 32'(data_out), 32'h77);

        // 5c. Simultaneous when full: only the read lands.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i));
        cyc(1'b1, 1'b1, 8'hEE);
        check("simF_dout", 32'(data_out), 32'h30);
        check("simF_full", 32'(full), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            check("simF_drain", 32'(data_out), 32'(8'h30 + i));
        end
        check("simF_empty", 32'(empty), 32'd1);

        // 6. Random stream across pointer wraps, occupancy kept in 1..7.
        cyc(1'b1, 1'b0, 8'($urandom));
        occ  = 1;
        sent = 1;
        iter = 0;
        while (sent < 20 && iter < 500) begin
            iter++;
            r = $urandom_range(0, 2);
            if (occ == 1 && r == 1) r = 0;
            if (occ == 7 && r == 0) r = 1;
            case (r)
                0: begin cyc(1'b1, 1'b0, 8'($urandom)); occ++; sent++; end
                1: begin cyc(1'b0, 1'b1, 8'h00); occ--; end
                default: begin cyc(1'b1, 1'b1, 8'($urandom)); sent++; end
            endcase
        end
        check("stream_sent", 32'(sent), 32'd20);
        while (occ > 0) begin
            cyc(1'b0, 1'b1, 8'h00);
            occ--;
        end
        check("stream_empty", 32'(empty), 32'd1);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
